// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: FSM state encodings and the
// default counter width.
package phase_sequencer_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_GAP  = 3'd2,
    ST_PH2  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/sta_edge_det.sv
// Rising-edge detector for the start request. The history flop resets to 1
// so a start level held through reset release is not seen as an edge.
module sta_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sta,
  output logic sta_rise_c
);

  logic sta_d_q;
  logic sta_d_d;

  always_comb begin
    sta_d_d = sta;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sta_d_q <= 1'b1;
    end else begin
      sta_d_q <= sta_d_d;
    end
  end

  assign sta_rise_c = sta & ~sta_d_q;

endmodule

// File: rtl/phase_sequencer.sv
// Start-triggered q1 / gap / q2 / done timing controller with programmable
// phase lengths. Optional macro PHASE_SEQ_RETRIGGER_EN lets a start edge abort a run.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sta,
  input  logic [CNT_W-1:0] t1_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] t2_len,
  output logic             q1,
  output logic             q2,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] t2_q, t2_d;
  logic             q1_q, q1_d;
  logic             q2_q, q2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sta_rise_c;
  logic             start_c;
  logic             enter_ph1, enter_gap, enter_ph2;
  logic [CNT_W-1:0] gap_src, t2_src;

  sta_edge_det u_sta_edge_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .sta        (sta),
    .sta_rise_c (sta_rise_c)
  );

`ifdef PHASE_SEQ_RETRIGGER_EN
  assign start_c = sta_rise_c;
`else
  assign start_c = sta_rise_c & (state_q == ST_IDLE);
`endif

  // Next state; zero-length phases fall through to the following phase in the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    t2_d      = t2_q;
    enter_ph1 = 1'b0;
    enter_gap = 1'b0;
    enter_ph2 = 1'b0;
    gap_src   = start_c ? gap_len : gap_q;
    t2_src    = start_c ? t2_len  : t2_q;

    if (start_c) begin
      gap_d     = gap_len;
      t2_d      = t2_len;
      enter_ph1 = 1'b1;
    end else begin
      case (state_q)
        ST_PH1: begin
          if (cnt_q == CNT_W'(0)) enter_gap = 1'b1;
          else                    cnt_d = cnt_q - CNT_W'(1);
        end
        ST_GAP: begin
          if (cnt_q == CNT_W'(0)) enter_ph2 = 1'b1;
          else                    cnt_d = cnt_q - CNT_W'(1);
        end
        ST_PH2: begin
          if (cnt_q == CNT_W'(0)) state_d = ST_DONE;
          else                    cnt_d = cnt_q - CNT_W'(1);
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (enter_ph1) begin
      if (t1_len != CNT_W'(0)) begin
        state_d = ST_PH1;
        cnt_d   = t1_len - CNT_W'(1);
      end else begin
        enter_gap = 1'b1;
      end
    end

    if (enter_gap) begin
      if (gap_src != CNT_W'(0)) begin
        state_d = ST_GAP;
        cnt_d   = gap_src - CNT_W'(1);
      end else begin
        enter_ph2 = 1'b1;
      end
    end

    if (enter_ph2) begin
      if (t2_src != CNT_W'(0)) begin
        state_d = ST_PH2;
        cnt_d   = t2_src - CNT_W'(1);
      end else begin
        state_d = ST_DONE;
        cnt_d   = CNT_W'(0);
      end
    end
  end

  // Outputs decode from the next state so they line up with the state register.
  always_comb begin
    q1_d   = (state_d == ST_PH1);
    q2_d   = (state_d == ST_PH2);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      t2_q    <= '0;
      q1_q    <= 1'b0;
      q2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      t2_q    <= t2_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q1   = q1_q;
  assign q2   = q2_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer; expectations follow the PHASE_SEQ_RETRIGGER_EN setting.
module tb_phase_sequencer;
  import phase_sequencer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       sta;
  logic [7:0] t1_len, gap_len, t2_len;
  logic       q1, q2, busy, done;

  logic       sta4;
  logic [3:0] t1_4, gap_4, t2_4;
  logic       q1_4, q2_4, busy_4, done_4;

  int n_checks;
  int n_fail;

  phase_sequencer #(.CNT_W(CNT_W_DEF)) dut (
    .clk(clk), .rst_n(rst_n), .sta(sta),
    .t1_len(t1_len), .gap_len(gap_len), .t2_len(t2_len),
    .q1(q1), .q2(q2), .busy(busy), .done(done)
  );

  phase_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sta(sta4),
    .t1_len(t1_4), .gap_len(gap_4), .t2_len(t2_4),
    .q1(q1_4), .q2(q2_4), .busy(busy_4), .done(done_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // q1 and q2 must never overlap on either instance.
  always @(negedge clk) begin
    n_checks = n_checks + 1;
    if ((q1 & q2) !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL overlap t=%0t q1=%b q2=%b required q1&q2=0", $time, q1, q2);
    end
    n_checks = n_checks + 1;
    if ((q1_4 & q2_4) !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL overlap4 t=%0t q1=%b q2=%b required q1&q2=0", $time, q1_4, q2_4);
    end
  end

  task automatic kick(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    t1_len = a; gap_len = b; t2_len = c;
    sta = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sta = 1'b0; sta4 = 1'b0;
    t1_len = '0; gap_len = '0; t2_len = '0;
    t1_4 = '0; gap_4 = '0; t2_4 = '0;
    repeat (2) @(negedge clk);
    n_checks = n_checks + 1;
    if ({q1, q2, busy, done} !== 4'b0000) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_hold got q1q2busydone=%b required 0000", {q1, q2, busy, done});
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks = n_checks + 1;
      if ({q1, q2, busy, done} !== 4'b0000) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_idle got q1q2busydone=%b required 0000", {q1, q2, busy, done});
      end
    end
  endtask

  task automatic test_basic;
    logic eq1, eq2, edn, ebs;
    kick(8'd3, 8'd2, 8'd4);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 0) sta = 1'b0;
      eq1 = (k < 3);
      eq2 = (k >= 5) && (k < 9);
      edn = (k == 9);
      ebs = (k <= 9);
      n_checks = n_checks + 1;
      if ({q1, q2, done, busy} !== {eq1, eq2, edn, ebs}) begin
        n_fail = n_fail + 1;
        $display("FAIL basic k=%0d got q1q2donebusy=%b required %b", k, {q1, q2, done, busy}, {eq1, eq2, edn, ebs});
      end
    end
  endtask

  task automatic test_zero_skip;
    logic eq2, edn, ebs;
    kick(8'd0, 8'd0, 8'd2);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) sta = 1'b0;
      eq2 = (k < 2);
      edn = (k == 2);
      ebs = (k <= 2);
      n_checks = n_checks + 1;
      if ({q1, q2, done, busy} !== {1'b0, eq2, edn, ebs}) begin
        n_fail = n_fail + 1;
        $display("FAIL zero_t2 k=%0d got q1q2donebusy=%b required %b", k, {q1, q2, done, busy}, {1'b0, eq2, edn, ebs});
      end
    end
    kick(8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) sta = 1'b0;
      edn = (k == 0);
      n_checks = n_checks + 1;
      if ({q1, q2, done, busy} !== {1'b0, 1'b0, edn, edn}) begin
        n_fail = n_fail + 1;
        $display("FAIL zero_all k=%0d got q1q2donebusy=%b required %b", k, {q1, q2, done, busy}, {1'b0, 1'b0, edn, edn});
      end
    end
  endtask

  task automatic test_busy_start;
    logic eq1, eq2, edn, ebs;
    kick(8'd3, 8'd2, 8'd4);
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      if (k == 0) sta = 1'b0;
`ifdef PHASE_SEQ_RETRIGGER_EN
      eq1 = (k < 3) || ((k >= 6) && (k < 9));
      eq2 = (k == 5) || ((k >= 11) && (k < 15));
      edn = (k == 15);
      ebs = (k <= 15);
`else
      eq1 = (k < 3);
      eq2 = (k >= 5) && (k < 9);
      edn = (k == 9);
      ebs = (k <= 9);
`endif
      n_checks = n_checks + 1;
      if ({q1, q2, done, busy} !== {eq1, eq2, edn, ebs}) begin
        n_fail = n_fail + 1;
        $display("FAIL busy_start k=%0d got q1q2donebusy=%b required %b", k, {q1, q2, done, busy}, {eq1, eq2, edn, ebs});
      end
      if (k == 5) sta = 1'b1;
      if (k == 6) sta = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run;
    kick(8'd3, 8'd2, 8'd4);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) sta = 1'b0;
    end
    n_checks = n_checks + 1;
    if (busy !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL gap_busy got busy=%b required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks = n_checks + 1;
    if ({q1, q2, busy, done} !== 4'b0000) begin
      n_fail = n_fail + 1;
      $display("FAIL async_reset got q1q2busydone=%b required 0000", {q1, q2, busy, done});
    end
    sta = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_checks = n_checks + 1;
      if ({q1, q2, busy, done} !== 4'b0000) begin
        n_fail = n_fail + 1;
        $display("FAIL held_sta k=%0d got q1q2busydone=%b required 0000", k, {q1, q2, busy, done});
      end
    end
    @(negedge clk);
    sta = 1'b0;
    kick(8'd1, 8'd0, 8'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) sta = 1'b0;
      n_checks = n_checks + 1;
      if ({q1, q2, done, busy} !== {k == 0, k == 1, k == 2, k <= 2}) begin
        n_fail = n_fail + 1;
        $display("FAIL restart k=%0d got q1q2donebusy=%b required %b", k, {q1, q2, done, busy}, {k == 0, k == 1, k == 2, k <= 2});
      end
    end
  endtask

  task automatic test_max_count;
    @(negedge clk);
    t1_4 = 4'd15; gap_4 = 4'd0; t2_4 = 4'd1;
    sta4 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      if (k == 0) sta4 = 1'b0;
      n_checks = n_checks + 1;
      if ({q1_4, q2_4, done_4, busy_4} !== {k < 15, k == 15, k == 16, k <= 16}) begin
        n_fail = n_fail + 1;
        $display("FAIL max_count k=%0d got q1q2donebusy=%b required %b", k, {q1_4, q2_4, done_4, busy_4}, {k < 15, k == 15, k == 16, k <= 16});
      end
    end
  endtask

  task automatic test_len_change;
    kick(8'd2, 8'd1, 8'd3);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        sta = 1'b0;
        t1_len = 8'd9; gap_len = 8'd5; t2_len = 8'd7;
      end
      n_checks = n_checks + 1;
      if ({q1, q2, done, busy} !== {k < 2, (k >= 3) && (k < 6), k == 6, k <= 6}) begin
        n_fail = n_fail + 1;
        $display("FAIL len_change k=%0d got q1q2donebusy=%b required %b", k, {q1, q2, done, busy}, {k < 2, (k >= 3) && (k < 6), k == 6, k <= 6});
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_zero_skip();
    test_busy_start();
    test_reset_mid_run();
    test_max_count();
    test_len_change();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
